ddsm_seq_ctrl: RTL and testbench

Sequencing controller for the MASH 1-1-1 delta-sigma modulator: owns the fractional frequency control word (FCW), the accumulator clear and enable, and the LSB dither source. It brings the modulator out of idle, holds off the noise-cancellation network's output valid until its pipeline has settled, and applies new FCWs only on fixed update boundaries. It sits between the configuration interface and the accumulator/NC-network datapath.

---
 rtl/ddsm_seq_ctrl_if.sv | 21 ++
 rtl/ddsm_seq_ctrl.sv | 108 ++++++++++
 tb/tb_ddsm_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ddsm_seq_ctrl_if.sv
// FCW request/accept handshake between the configuration side and the
// delta-sigma sequencing controller.
interface ddsm_seq_ctrl_if #(
    parameter int P_FCW_W = 24
);
    logic [P_FCW_W-1:0] i_fcw;
    logic               i_fcw_valid;
    logic               o_fcw_ready;

    modport master (
        output i_fcw,
        output i_fcw_valid,
        input  o_fcw_ready
    );

    modport slave (
        input  i_fcw,
        input  i_fcw_valid,
        output o_fcw_ready
    );
endinterface

// File: rtl/ddsm_seq_ctrl.sv
// Sequencing controller for a MASH 1-1-1 delta-sigma modulator: start-up FSM,
// boundary-aligned FCW updates and a 15-bit LFSR LSB dither source.
module ddsm_seq_ctrl #(
    parameter int                 P_FCW_W      = 24,
    parameter int                 P_SETTLE     = 3,
    parameter int                 P_UPD_PERIOD = 16,
    parameter logic [P_FCW_W-1:0] P_FCW_RST    = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    ddsm_seq_ctrl_if.slave     cfg,
    input  logic               i_dither_en,
    output logic [P_FCW_W-1:0] o_fcw,
    output logic               o_acc_clr,
    output logic               o_acc_en,
    output logic               o_dither,
    output logic               o_div_valid,
    output logic [1:0]         o_state
);
    localparam int SET_W = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
    localparam int UPD_W = $clog2(P_UPD_PERIOD);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(P_SETTLE - 1);
    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(P_UPD_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_WARM  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SET_W-1:0]   set_cnt;
    logic [UPD_W-1:0]   upd_cnt;
    logic [P_FCW_W-1:0] pend;
    logic               pend_v;
    logic [14:0]        lfsr;
    logic               xfer;
    logic               tick;

    assign cfg.o_fcw_ready = (state == S_IDLE) | ~pend_v;
    assign xfer            = cfg.i_fcw_valid & cfg.o_fcw_ready;
    assign tick            = (state == S_RUN) && (upd_cnt == UPD_LAST);
    assign o_state         = state;
    assign o_dither        = lfsr[0] & i_dither_en & o_acc_en;

    always_comb begin
        state_nxt = state;
        if (!i_en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_FLUSH;
                S_FLUSH: state_nxt = S_WARM;
                S_WARM:  if (set_cnt == SET_LAST) state_nxt = S_RUN;
                default: state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            o_acc_clr   <= 1'b1;
            o_acc_en    <= 1'b0;
            o_div_valid <= 1'b0;
            set_cnt     <= '0;
            upd_cnt     <= '0;
            o_fcw       <= P_FCW_RST;
            pend        <= '0;
            pend_v      <= 1'b0;
            lfsr        <= 15'h0001;
        end else begin
            state       <= state_nxt;
            o_acc_clr   <= (state_nxt == S_IDLE) || (state_nxt == S_FLUSH);
            o_acc_en    <= (state_nxt == S_WARM) || (state_nxt == S_RUN);
            o_div_valid <= (state_nxt == S_RUN);

            set_cnt <= (state == S_WARM) ? set_cnt + SET_W'(1) : '0;

            if (state == S_RUN && state_nxt == S_RUN)
                upd_cnt <= (upd_cnt == UPD_LAST) ? '0 : upd_cnt + UPD_W'(1);
            else
                upd_cnt <= '0;

            // A word accepted on the cycle i_en drops is newer than any
            // pending one, so it wins on the way back to IDLE.
            if (state == S_IDLE) begin
                if (xfer) o_fcw <= cfg.i_fcw;
            end else if (state_nxt == S_IDLE) begin
                if (xfer)        o_fcw <= cfg.i_fcw;
                else if (pend_v) o_fcw <= pend;
                pend_v <= 1'b0;
            end else if (tick && pend_v) begin
                o_fcw  <= pend;
                pend_v <= 1'b0;
            end else if (xfer) begin
                pend   <= cfg.i_fcw;
                pend_v <= 1'b1;
            end

            if (o_acc_en && i_dither_en)
                lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        end
    end
endmodule

// File: tb/tb_ddsm_seq_ctrl.sv
// Directed bench for ddsm_seq_ctrl: start-up sequence, FCW handshake timing,
// dither stream against an x^15+x^14+1 reference and reset behaviour.
module tb_ddsm_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        dither_en;
    logic [23:0] fcw;
    logic        acc_clr;
    logic        acc_en;
    logic        dither;
    logic        div_valid;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;
    logic [14:0] m;

    ddsm_seq_ctrl_if #(.P_FCW_W(24)) cfg ();

    ddsm_seq_ctrl #(
        .P_FCW_W      (24),
        .P_SETTLE     (3),
        .P_UPD_PERIOD (16),
        .P_FCW_RST    (24'h000000)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .cfg         (cfg),
        .i_dither_en (dither_en),
        .o_fcw       (fcw),
        .o_acc_clr   (acc_clr),
        .o_acc_en    (acc_en),
        .o_dither    (dither),
        .o_div_valid (div_valid),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dither_en = 1'b0;
        cfg.i_fcw = '0; cfg.i_fcw_valid = 1'b0;
        step(); step();

        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fcw", 32'(fcw), 32'h0);
        chk("rst_clr", 32'(acc_clr), 32'd1);
        chk("rst_en", 32'(acc_en), 32'd0);
        chk("rst_valid", 32'(div_valid), 32'd0);
        chk("rst_dither", 32'(dither), 32'd0);
        chk("rst_ready", 32'(cfg.o_fcw_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // IDLE transfer lands on o_fcw one edge later
        cfg.i_fcw = 24'h123456; cfg.i_fcw_valid = 1'b1;
        step();
        cfg.i_fcw_valid = 1'b0;
        chk("idle_fcw", 32'(fcw), 32'h123456);
        chk("idle_clr", 32'(acc_clr), 32'd1);
        chk("idle_valid", 32'(div_valid), 32'd0);
        chk("idle_state", 32'(state), 32'd0);

        // start-up: 1,2,2,2,3
        en = 1'b1;
        step(); chk("seq0", 32'(state), 32'd1); chk("flush_clr", 32'(acc_clr), 32'd1);
        chk("flush_en", 32'(acc_en), 32'd0);
        step(); chk("seq1", 32'(state), 32'd2); chk("warm_clr", 32'(acc_clr), 32'd0);
        chk("warm_en", 32'(acc_en), 32'd1);
        step(); chk("seq2", 32'(state), 32'd2);
        step(); chk("seq3", 32'(state), 32'd2); chk("warm_valid", 32'(div_valid), 32'd0);
        step(); chk("seq4", 32'(state), 32'd3); chk("run_valid", 32'(div_valid), 32'd1);

        // period count is 0 now; advance to count 3 and request
        step(); step(); step();
        cfg.i_fcw = 24'h00ABCD; cfg.i_fcw_valid = 1'b1;
        step();
        cfg.i_fcw_valid = 1'b0;
        chk("run_ready_low", 32'(cfg.o_fcw_ready), 32'd0);
        chk("run_fcw_hold0", 32'(fcw), 32'h123456);
        for (int i = 0; i < 11; i++) step();
        chk("run_fcw_hold15", 32'(fcw), 32'h123456);
        chk("run_ready_hold", 32'(cfg.o_fcw_ready), 32'd0);
        step();
        chk("run_fcw_tick", 32'(fcw), 32'h00ABCD);
        chk("run_ready_back", 32'(cfg.o_fcw_ready), 32'd1);

        // pending word flushed to o_fcw on the way to IDLE
        cfg.i_fcw = 24'h777777; cfg.i_fcw_valid = 1'b1;
        step();
        cfg.i_fcw_valid = 1'b0;
        chk("pend_ready_low", 32'(cfg.o_fcw_ready), 32'd0);
        chk("pend_fcw_hold", 32'(fcw), 32'h00ABCD);
        en = 1'b0;
        step();
        chk("drop_state", 32'(state), 32'd0);
        chk("drop_fcw", 32'(fcw), 32'h777777);
        chk("drop_ready", 32'(cfg.o_fcw_ready), 32'd1);
        chk("drop_clr", 32'(acc_clr), 32'd1);
        chk("drop_valid", 32'(div_valid), 32'd0);

        // dither stream from seed 1 over more than a full period
        dither_en = 1'b1;
        chk("idle_dither", 32'(dither), 32'd0);
        en = 1'b1;
        step();
        chk("flush_dither", 32'(dither), 32'd0);
        m = 15'h0001;
        step();
        chk("dither_first", 32'(dither), 32'(m[0]));
        for (int i = 0; i < 32800; i++) begin
            step();
            m = {m[13:0], m[14] ^ m[13]};
            if (dither !== m[0]) chk("dither_stream", 32'(dither), 32'(m[0]));
        end
        chk("dither_last", 32'(dither), 32'(m[0]));
        en = 1'b0;
        step();
        chk("dither_idle_after", 32'(dither), 32'd0);
        chk("dither_idle_state", 32'(state), 32'd0);
        dither_en = 1'b0;

        // reset in WARM with a word pending
        en = 1'b1;
        step();
        cfg.i_fcw = 24'h55AA55; cfg.i_fcw_valid = 1'b1;
        step();
        cfg.i_fcw_valid = 1'b0;
        chk("mid_state", 32'(state), 32'd2);
        chk("mid_ready_low", 32'(cfg.o_fcw_ready), 32'd0);
        rst_n = 1'b0;
        step();
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_fcw", 32'(fcw), 32'h0);
        chk("mrst_ready", 32'(cfg.o_fcw_ready), 32'd1);
        chk("mrst_clr", 32'(acc_clr), 32'd1);
        chk("mrst_en", 32'(acc_en), 32'd0);
        chk("mrst_valid", 32'(div_valid), 32'd0);
        chk("mrst_dither", 32'(dither), 32'd0);
        rst_n = 1'b1; en = 1'b0;
        step();
        chk("mrst_no_apply", 32'(fcw), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
